// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and drives it to instr_mem.
// Captures the returned word into the IF/ID register; handles stall/flush/redirect/halt.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic        halted_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT,
        S_ERR
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        target_aligned;
    logic        is_ebreak;

    always_comb begin
        pc_plus4       = pc + 32'd4;
        target_aligned = (redirect_pc_i[1:0] == 2'b00);
        is_ebreak      = (imem_data_i == EBREAK_INSTR);
    end

    assign imem_addr_o = pc;

    // A bubble only replaces instr/valid; ifid_pc/pc4 keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            ifid_instr_o <= NOP_INSTR;
            ifid_pc_o    <= '0;
            ifid_pc4_o   <= '0;
            ifid_valid_o <= 1'b0;
            halted_o     <= 1'b0;
            misalign_o   <= 1'b0;
            fetch_cnt_o  <= '0;
        end else begin
            case (state)
                S_BOOT: begin
                    ifid_instr_o <= NOP_INSTR;
                    ifid_valid_o <= 1'b0;
                    state        <= S_RUN;
                end

                S_RUN: begin
                    if (redirect_i) begin
                        ifid_instr_o <= NOP_INSTR;
                        ifid_valid_o <= 1'b0;
                        if (target_aligned) begin
                            pc <= redirect_pc_i;
                        end else begin
                            misalign_o <= 1'b1;
                            state      <= S_ERR;
                        end
                    end else if (flush_i) begin
                        // pc holds so the killed word is refetched next cycle
                        ifid_instr_o <= NOP_INSTR;
                        ifid_valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        ifid_instr_o <= imem_data_i;
                        ifid_pc_o    <= pc;
                        ifid_pc4_o   <= pc_plus4;
                        ifid_valid_o <= 1'b1;
                        fetch_cnt_o  <= fetch_cnt_o + 32'd1;
                        if (is_ebreak) begin
                            halted_o <= 1'b1;
                            state    <= S_HALT;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end

                S_HALT: begin
                    ifid_instr_o <= NOP_INSTR;
                    ifid_valid_o <= 1'b0;
                    if (redirect_i) begin
                        halted_o <= 1'b0;
                        if (target_aligned) begin
                            pc    <= redirect_pc_i;
                            state <= S_RUN;
                        end else begin
                            misalign_o <= 1'b1;
                            state      <= S_ERR;
                        end
                    end
                end

                S_ERR: begin
                    ifid_instr_o <= NOP_INSTR;
                    ifid_valid_o <= 1'b0;
                    misalign_o   <= 1'b1;
                end

                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: small instruction memory model and
// hand-computed expectations along a fixed stall/flush/redirect/halt/error script.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic        halted_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;

    logic [31:0] mem [64];
    int unsigned n_checks;
    int unsigned n_pass;

    if_fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .NOP_INSTR   (NOP),
        .EBREAK_INSTR(EBREAK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .ifid_instr_o (ifid_instr_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_valid_o (ifid_valid_o),
        .halted_o     (halted_o),
        .misalign_o   (misalign_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data_i = mem[imem_addr_o[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
        stall_i       = st;
        flush_i       = fl;
        redirect_i    = rd;
        redirect_pc_i = tgt;
    endtask

    task automatic check_bubble(input string tag, input logic [31:0] exp_addr);
        check({tag, ".instr"}, ifid_instr_o, NOP);
        check({tag, ".valid"}, {31'd0, ifid_valid_o}, 32'd0);
        check({tag, ".addr"}, imem_addr_o, exp_addr);
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                               input logic [31:0] exp_addr, input logic [31:0] exp_cnt);
        check({tag, ".pc"}, ifid_pc_o, exp_pc);
        check({tag, ".pc4"}, ifid_pc4_o, exp_pc + 32'd4);
        check({tag, ".instr"}, ifid_instr_o, exp_instr);
        check({tag, ".valid"}, {31'd0, ifid_valid_o}, 32'd1);
        check({tag, ".addr"}, imem_addr_o, exp_addr);
        check({tag, ".cnt"}, fetch_cnt_o, exp_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int unsigned i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;
        mem[8] = EBREAK;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        check("rst.addr", imem_addr_o, 32'h0);
        check("rst.instr", ifid_instr_o, NOP);
        check("rst.pc", ifid_pc_o, 32'h0);
        check("rst.pc4", ifid_pc4_o, 32'h0);
        check("rst.valid", {31'd0, ifid_valid_o}, 32'd0);
        check("rst.halted", {31'd0, halted_o}, 32'd0);
        check("rst.misalign", {31'd0, misalign_o}, 32'd0);
        check("rst.cnt", fetch_cnt_o, 32'd0);
        rst = 1'b0;

        // boot cycle ignores redirect/flush/stall
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        step(); check_bubble("boot", 32'h0);
        drive(1'b0, 1'b0, 1'b0, '0);
        step(); check_fetch("f0", 32'h0, 32'h0050_0093, 32'h4, 32'd1);
        step(); check_fetch("f4", 32'h4, 32'h00A0_0113, 32'h8, 32'd2);

        drive(1'b1, 1'b0, 1'b0, '0);
        step(); check_fetch("stall1", 32'h4, 32'h00A0_0113, 32'h8, 32'd2);
        step(); check_fetch("stall2", 32'h4, 32'h00A0_0113, 32'h8, 32'd2);
        drive(1'b0, 1'b0, 1'b0, '0);
        step(); check_fetch("f8", 32'h8, 32'h0020_81B3, 32'hC, 32'd3);

        // redirect wins over stall and flush
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        step(); check_bubble("redir40", 32'h40);
        check("redir40.pc_hold", ifid_pc_o, 32'h8);
        drive(1'b0, 1'b0, 1'b0, '0);
        step(); check_fetch("f40", 32'h40, 32'hA000_0010, 32'h44, 32'd4);

        drive(1'b0, 1'b0, 1'b1, 32'h0000_0010);
        step(); check_bubble("redir10", 32'h10);
        drive(1'b0, 1'b1, 1'b0, '0);
        step(); check_bubble("flush10", 32'h10);
        check("flush10.cnt", fetch_cnt_o, 32'd4);
        drive(1'b0, 1'b0, 1'b0, '0);
        step(); check_fetch("f10", 32'h10, 32'hA000_0004, 32'h14, 32'd5);

        drive(1'b0, 1'b0, 1'b1, 32'h0000_0020);
        step(); check_bubble("redir20", 32'h20);
        drive(1'b0, 1'b0, 1'b0, '0);
        step(); check_fetch("ebreak", 32'h20, EBREAK, 32'h20, 32'd6);
        check("ebreak.halted", {31'd0, halted_o}, 32'd1);
        for (int unsigned i = 0; i < 5; i++) begin
            drive(i[0], i[1], 1'b0, '0);
            step(); check_bubble("halt", 32'h20);
            check("halt.halted", {31'd0, halted_o}, 32'd1);
            check("halt.cnt", fetch_cnt_o, 32'd6);
        end
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0080);
        step(); check_bubble("resume", 32'h80);
        check("resume.halted", {31'd0, halted_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0);
        step(); check_fetch("f80", 32'h80, 32'hA000_0020, 32'h84, 32'd7);

        drive(1'b0, 1'b0, 1'b1, 32'h0000_0042);
        step(); check_bubble("mis", 32'h84);
        check("mis.flag", {31'd0, misalign_o}, 32'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0000_0040);
            step(); check_bubble("err", 32'h84);
            check("err.flag", {31'd0, misalign_o}, 32'd1);
            check("err.cnt", fetch_cnt_o, 32'd7);
        end

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        check("rst2.misalign", {31'd0, misalign_o}, 32'd0);
        check("rst2.addr", imem_addr_o, 32'h0);
        check("rst2.cnt", fetch_cnt_o, 32'd0);
        rst = 1'b0;
        step(); check_bubble("boot2", 32'h0);
        step(); check_fetch("f0b", 32'h0, 32'h0050_0093, 32'h4, 32'd1);

        // PC wraps modulo 2^32
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(); check_bubble("redirtop", 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, '0);
        step(); check_fetch("wrap", 32'hFFFF_FFFC, 32'hA000_003F, 32'h0, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
